// File: rtl/bus_arbiter_2m_if.sv
// rtl/bus_arbiter_2m_if.sv - request/grant bundle between two bus masters and the arbiter
interface bus_arbiter_2m_if;
  logic m0_breq;
  logic m1_breq;
  logic bus_busy;
  logic m0_bgrant;
  logic m1_bgrant;
  logic msel;
  logic split_hold;

  modport master (
    output m0_breq, m1_breq, bus_busy,
    input  m0_bgrant, m1_bgrant, msel, split_hold
  );

  modport slave (
    input  m0_breq, m1_breq, bus_busy,
    output m0_bgrant, m1_bgrant, msel, split_hold
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// rtl/bus_arbiter_2m.sv - two-master bus arbiter, fixed or round-robin priority with hold-limit preemption
module bus_arbiter_2m #(
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  bus_arbiter_2m_if.slave  bus
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  state_t        state;
  logic          run;
  logic          last_owner;
  logic          msel_q;
  logic          split_q;
  logic [HW-1:0] hold_cnt;

  logic own_req;
  logic oth_req;
  logic release_c;
  logic preempt_c;
  logic pick_m1;

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    case (state)
      OWN_M0: begin
        own_req = bus.m0_breq;
        oth_req = bus.m1_breq;
      end
      OWN_M1: begin
        own_req = bus.m1_breq;
        oth_req = bus.m0_breq;
      end
      default: begin
        own_req = 1'b0;
        oth_req = 1'b0;
      end
    endcase
    release_c = (state != IDLE) && !own_req;
    preempt_c = (MAX_HOLD != 0) && (state != IDLE) && (hold_cnt == HOLD_MAX) && oth_req;
  end

  // On a tie, round robin hands the bus to whichever master did not own it last.
  assign pick_m1 = bus.m1_breq &&
                   (!bus.m0_breq || ((RR_MODE != 0) && (last_owner == 1'b0)));

  // run gates the first edge after reset release so that release is synchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      run        <= 1'b0;
      last_owner <= 1'b1;
      msel_q     <= 1'b0;
      split_q    <= 1'b0;
      hold_cnt   <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      split_q <= (release_c || preempt_c) && bus.bus_busy;
      case (state)
        IDLE: begin
          if (bus.m0_breq || bus.m1_breq) begin
            state      <= pick_m1 ? OWN_M1 : OWN_M0;
            last_owner <= pick_m1;
            msel_q     <= pick_m1;
            hold_cnt   <= '0;
          end
        end
        OWN_M0, OWN_M1: begin
          if ((release_c || preempt_c) && !bus.bus_busy) begin
            hold_cnt <= '0;
            if (oth_req) begin
              state      <= (state == OWN_M0) ? OWN_M1 : OWN_M0;
              last_owner <= (state == OWN_M0);
              msel_q     <= (state == OWN_M0);
            end else begin
              state <= IDLE;
            end
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.m0_bgrant  = (state == OWN_M0);
  assign bus.m1_bgrant  = (state == OWN_M1);
  assign bus.msel       = msel_q;
  assign bus.split_hold = split_q;
endmodule
